// File: rtl/sa_pkg.sv
// Shared definitions for the output-stationary systolic array.
// Holds the controller state enum and the default geometry/width constants
// used by systolic_array_mxn and sa_pe.
package sa_pkg;

  localparam int unsigned SA_ROWS       = 4;
  localparam int unsigned SA_COLS       = 4;
  localparam int unsigned SA_DATA_WIDTH = 16;
  localparam int unsigned SA_KW         = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } sa_state_e;

endpackage

// File: rtl/sa_pe.sv
// Processing element: signed MAC accumulator with east/south forwarding.
// Build option: define SA_SATURATE_EN to clamp the accumulator to the signed
// 2*DATA_WIDTH range instead of wrapping.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   clr           synchronous clear of accumulator and forwarding registers
//   en            accumulate enable
//   a_in, b_in    operands from the west / north neighbour
//   a_out, b_out  registered operands to the east / south neighbour
//   acc           accumulated C[i][j]
module sa_pe
  import sa_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SA_DATA_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clr,
  input  logic                           en,
  input  logic signed [DATA_WIDTH-1:0]   a_in,
  input  logic signed [DATA_WIDTH-1:0]   b_in,
  output logic signed [DATA_WIDTH-1:0]   a_out,
  output logic signed [DATA_WIDTH-1:0]   b_out,
  output logic signed [2*DATA_WIDTH-1:0] acc
);

  localparam int unsigned AW = 2 * DATA_WIDTH;

  logic signed [AW-1:0] prod;
  logic signed [AW-1:0] acc_next;

  // Full-precision signed product.
  always_comb prod = AW'(a_in) * AW'(b_in);

`ifdef SA_SATURATE_EN
  logic signed [AW:0] sum;

  // One extra bit exposes overflow; clamp when the top two bits disagree.
  always_comb begin
    sum = (AW+1)'(acc) + (AW+1)'(prod);
    if (sum[AW] != sum[AW-1]) begin
      acc_next = sum[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    end else begin
      acc_next = sum[AW-1:0];
    end
  end
`else
  // Natural two's-complement wrap.
  always_comb acc_next = acc + prod;
`endif

  // Forwarding registers always shift; accumulator only while enabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else if (clr) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else begin
      a_out <= a_in;
      b_out <= b_in;
      if (en) acc <= acc_next;
    end
  end

endmodule

// File: rtl/systolic_array_mxn.sv
// ROWS x COLS output-stationary systolic matrix multiplier, C = A x B.
// One column of A and one row of B are accepted per in_valid&&in_ready beat;
// after K beats the array is flushed and C is drained one row per handshake.
// Build option: SA_SATURATE_EN selects saturating accumulation in sa_pe.
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   start, k_len, busy    job request (accepted in IDLE), inner dimension, busy flag
//   a_data, b_data        A column (row i in slice i), B row (column j in slice j)
//   in_valid, in_ready    input beat handshake
//   out_data, out_row     one row of C and its index
//   out_valid, out_ready  output row handshake
//   out_last              marks row ROWS-1
module systolic_array_mxn
  import sa_pkg::*;
#(
  parameter int unsigned ROWS       = SA_ROWS,
  parameter int unsigned COLS       = SA_COLS,
  parameter int unsigned DATA_WIDTH = SA_DATA_WIDTH,
  parameter int unsigned KW         = SA_KW
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [KW-1:0]                  k_len,
  output logic                           busy,
  input  logic [ROWS*DATA_WIDTH-1:0]     a_data,
  input  logic [COLS*DATA_WIDTH-1:0]     b_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [COLS*2*DATA_WIDTH-1:0]   out_data,
  output logic [$clog2(ROWS)-1:0]        out_row,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_last
);

  localparam int unsigned AW = 2 * DATA_WIDTH;
  localparam int unsigned RW = $clog2(ROWS);
  localparam int unsigned FW = $clog2(ROWS + COLS);

  sa_state_e state, state_next;

  logic            busy_d, in_ready_d;
  logic            clr, acc_en;
  logic            beat_fire, last_beat, flush_done, drain_fire;
  logic [KW-1:0]   k_len_q, beat_cnt;
  logic [FW-1:0]   flush_cnt;
  logic [RW-1:0]   drain_sel;
  logic [COLS*AW-1:0] row_data;

  logic signed [DATA_WIDTH-1:0] a_link [ROWS][COLS+1];
  logic signed [DATA_WIDTH-1:0] b_link [ROWS+1][COLS];
  logic signed [AW-1:0]         acc    [ROWS][COLS];

  assign beat_fire  = in_valid && in_ready;
  assign last_beat  = beat_fire && (beat_cnt == k_len_q - KW'(1));
  assign flush_done = (state == FLUSH) && (flush_cnt == FW'(ROWS + COLS - 2));
  assign drain_fire = out_valid && out_ready;

  // State register plus registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      in_ready <= 1'b0;
    end else begin
      state    <= state_next;
      busy     <= busy_d;
      in_ready <= in_ready_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (k_len == '0) ? FLUSH : LOAD;
      LOAD:    if (last_beat) state_next = FLUSH;
      FLUSH:   if (flush_done) state_next = DRAIN;
      DRAIN:   if (drain_fire && out_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output/control decode.
  always_comb begin
    busy_d     = 1'b0;
    in_ready_d = 1'b0;
    clr        = 1'b0;
    acc_en     = 1'b0;
    busy_d     = (state_next != IDLE);
    in_ready_d = (state_next == LOAD);
    clr        = (state == IDLE) && start;
    acc_en     = (state == LOAD) || (state == FLUSH);
  end

  // Job length capture, accepted-beat counter and flush timer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_len_q   <= '0;
      beat_cnt  <= '0;
      flush_cnt <= '0;
    end else begin
      if (clr) begin
        k_len_q  <= k_len;
        beat_cnt <= '0;
      end else if (beat_fire) begin
        beat_cnt <= beat_cnt + KW'(1);
      end
      flush_cnt <= (state == FLUSH) ? flush_cnt + FW'(1) : '0;
    end
  end

  // Input skew: row i of A and column j of B are delayed i / j cycles.
  // Non-accepted cycles feed zeros so the diagonal wavefront stays aligned.
  for (genvar i = 0; i < ROWS; i++) begin : g_askew
    logic signed [DATA_WIDTH-1:0] a_src;
    always_comb a_src = beat_fire ? a_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
    if (i == 0) begin : g_direct
      assign a_link[i][0] = a_src;
    end else begin : g_dly
      logic signed [DATA_WIDTH-1:0] dly [i];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int k = 0; k < i; k++) dly[k] <= '0;
        end else if (clr) begin
          for (int k = 0; k < i; k++) dly[k] <= '0;
        end else begin
          dly[0] <= a_src;
          for (int k = 1; k < i; k++) dly[k] <= dly[k-1];
        end
      end
      assign a_link[i][0] = dly[i-1];
    end
  end

  for (genvar j = 0; j < COLS; j++) begin : g_bskew
    logic signed [DATA_WIDTH-1:0] b_src;
    always_comb b_src = beat_fire ? b_data[j*DATA_WIDTH +: DATA_WIDTH] : '0;
    if (j == 0) begin : g_direct
      assign b_link[0][j] = b_src;
    end else begin : g_dly
      logic signed [DATA_WIDTH-1:0] dly [j];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int k = 0; k < j; k++) dly[k] <= '0;
        end else if (clr) begin
          for (int k = 0; k < j; k++) dly[k] <= '0;
        end else begin
          dly[0] <= b_src;
          for (int k = 1; k < j; k++) dly[k] <= dly[k-1];
        end
      end
      assign b_link[0][j] = dly[j-1];
    end
  end

  // PE grid: A flows east, B flows south.
  for (genvar i = 0; i < ROWS; i++) begin : g_row
    for (genvar j = 0; j < COLS; j++) begin : g_col
      sa_pe #(
        .DATA_WIDTH (DATA_WIDTH)
      ) u_pe (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .en    (acc_en),
        .a_in  (a_link[i][j]),
        .b_in  (b_link[i][j]),
        .a_out (a_link[i][j+1]),
        .b_out (b_link[i+1][j]),
        .acc   (acc[i][j])
      );
    end
  end

  // Row about to be presented: row 0 on entering DRAIN, else the next row.
  always_comb begin
    drain_sel = (state == FLUSH) ? '0 : RW'(out_row + RW'(1));
  end

  always_comb begin
    row_data = '0;
    for (int j = 0; j < COLS; j++) row_data[j*AW +: AW] = acc[drain_sel][j];
  end

  // Output row register; holds while the consumer stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_row   <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (flush_done) begin
      out_valid <= 1'b1;
      out_row   <= '0;
      out_data  <= row_data;
      out_last  <= 1'b0;
    end else if (drain_fire) begin
      if (out_last) begin
        out_valid <= 1'b0;
        out_row   <= '0;
        out_data  <= '0;
        out_last  <= 1'b0;
      end else begin
        out_row   <= drain_sel;
        out_data  <= row_data;
        out_last  <= (drain_sel == RW'(ROWS - 1));
      end
    end
  end

endmodule

// File: tb/tb_systolic_array_mxn.sv
module tb_systolic_array_mxn;

  localparam int R  = 4;
  localparam int C  = 4;
  localparam int DW = 16;
  localparam int KW = 8;
  localparam int AW = 32;

  logic            clk;
  logic            rst;
  logic            start;
  logic [KW-1:0]   k_len;
  logic            busy;
  logic [R*DW-1:0] a_data;
  logic [C*DW-1:0] b_data;
  logic            in_valid;
  logic            in_ready;
  logic [C*AW-1:0] out_data;
  logic [1:0]      out_row;
  logic            out_valid;
  logic            out_ready;
  logic            out_last;

  systolic_array_mxn #(
    .ROWS(R), .COLS(C), .DATA_WIDTH(DW), .KW(KW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .busy(busy),
    .a_data(a_data), .b_data(b_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_row(out_row), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]      row;
    logic [C*AW-1:0] data;
    logic            last;
  } exp_t;

  exp_t sb[$];
  int a_m[R][8];
  int b_m[8][C];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every accepted output row is compared against the queue.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_row act_row=%0d exp=none", out_row);
      end else begin
        e = sb.pop_front();
        check("row_idx",  128'(out_row),  128'(e.row));
        check("row_data", 128'(out_data), 128'(e.data));
        check("row_last", 128'(out_last), 128'(e.last));
      end
    end
  end

  task automatic push_row(input int i, input logic [C*AW-1:0] d);
    exp_t e;
    e.row  = 2'(i);
    e.data = d;
    e.last = (i == R - 1);
    sb.push_back(e);
  endtask

  // Reference: plain matrix product with the same overflow rule as the build.
  task automatic push_model(input int k);
    logic [C*AW-1:0] d;
    longint s;
    for (int i = 0; i < R; i++) begin
      d = '0;
      for (int j = 0; j < C; j++) begin
        s = 0;
        for (int kk = 0; kk < k; kk++) begin
          s = s + longint'(a_m[i][kk]) * longint'(b_m[kk][j]);
`ifdef SA_SATURATE_EN
          if (s > 64'sd2147483647) s = 64'sd2147483647;
          if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
        end
        d[j*AW +: AW] = s[31:0];
      end
      push_row(i, d);
    end
  endtask

  task automatic start_job(input int k);
    start = 1'b1;
    k_len = KW'(k);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_beats(input int k, input bit gaps);
    bit rdy;
    int n;
    for (int kk = 0; kk < k; kk++) begin
      if (gaps && kk > 0) begin
        in_valid = 1'b0;
        a_data   = '1;
        b_data   = '1;
        @(posedge clk); #1;
      end
      for (int i = 0; i < R; i++) a_data[i*DW +: DW] = 16'(a_m[i][kk]);
      for (int j = 0; j < C; j++) b_data[j*DW +: DW] = 16'(b_m[kk][j]);
      in_valid = 1'b1;
      n = 0;
      rdy = 1'b0;
      while (!rdy && n < 20) begin
        @(negedge clk);
        rdy = in_ready;
        @(posedge clk); #1;
        n++;
      end
      if (!rdy) begin
        total++;
        bad++;
        $display("FAIL beat_accept act=timeout exp=accepted beat=%0d", kk);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("job_done", 128'(busy), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b0; start = 1'b0; k_len = '0; a_data = '0; b_data = '0;
    in_valid = 1'b0; out_ready = 1'b1;
    #12;
    check("rst_busy",      128'(busy),      128'(0));
    check("rst_in_ready",  128'(in_ready),  128'(0));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_last",  128'(out_last),  128'(0));
    check("rst_out_row",   128'(out_row),   128'(0));
    check("rst_out_data",  128'(out_data),  128'(0));

    // Test 1: A = identity, B[k][j] = 4k+j -> C rows equal B rows.
    for (int i = 0; i < R; i++)
      for (int k = 0; k < 4; k++) a_m[i][k] = (i == k) ? 1 : 0;
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < C; j++) b_m[k][j] = k * 4 + j;
    push_row(0, 128'h00000003_00000002_00000001_00000000);
    push_row(1, 128'h00000007_00000006_00000005_00000004);
    push_row(2, 128'h0000000b_0000000a_00000009_00000008);
    push_row(3, 128'h0000000f_0000000e_0000000d_0000000c);
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    k_len = 8'd4;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_after_rst", 128'(busy), 128'(1));
    send_beats(4, 1'b0);
    wait_idle();

    // Test 2: K=3, valid on every other cycle, signed operands.
    for (int i = 0; i < R; i++)
      for (int k = 0; k < 3; k++) a_m[i][k] = i * 3 - k * 2 - 1;
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < C; j++) b_m[k][j] = (j + 1) * (k - 1) + 5;
    push_model(3);
    start_job(3);
    send_beats(3, 1'b1);
    in_valid = 1'b1;
    a_data = '1;
    b_data = '1;
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      check("in_ready_flush_drain", 128'(in_ready), 128'(0));
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    wait_idle();

    // Test 3: stall 5 cycles on row 1.
    for (int i = 0; i < R; i++)
      for (int k = 0; k < 2; k++) a_m[i][k] = i + 1 + k;
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < C; j++) b_m[k][j] = j - k;
    push_model(2);
    start_job(2);
    send_beats(2, 1'b0);
    n = 0;
    while (!(out_valid && out_row == 2'd1) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("stall_reach_row1", 128'(out_row), 128'(1));
    out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      check("stall_row",   128'(out_row),   128'(sb[0].row));
      check("stall_data",  128'(out_data),  128'(sb[0].data));
      check("stall_valid", 128'(out_valid), 128'(1));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_idle();

    // Test 4: k_len=0 -> 7-cycle flush, zero rows; start while busy ignored.
    for (int i = 0; i < R; i++) push_row(i, '0);
    start_job(0);
    n = 0;
    while (!out_valid && n < 50) begin
      n++;
      start = (n == 2);
      k_len = 8'd5;
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("flush_len", 128'(n), 128'(7));
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    check("start_ignored", 128'(busy), 128'(0));

    // Test 5: A=B=0x7FFF, K=4.
    for (int i = 0; i < R; i++)
      for (int k = 0; k < 4; k++) a_m[i][k] = 32767;
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < C; j++) b_m[k][j] = 32767;
    for (int i = 0; i < R; i++)
`ifdef SA_SATURATE_EN
      push_row(i, {4{32'h7FFFFFFF}});
`else
      push_row(i, {4{32'hFFFC0004}});
`endif
    start_job(4);
    send_beats(4, 1'b0);
    wait_idle();

    // Test 6: reset mid-LOAD, then a K=2 job.
    start_job(4);
    send_beats(2, 1'b0);
    in_valid = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_busy",      128'(busy),      128'(0));
    check("mid_rst_in_ready",  128'(in_ready),  128'(0));
    check("mid_rst_out_valid", 128'(out_valid), 128'(0));
    check("mid_rst_out_last",  128'(out_last),  128'(0));
    check("mid_rst_out_row",   128'(out_row),   128'(0));
    check("mid_rst_out_data",  128'(out_data),  128'(0));
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < R; i++)
      for (int k = 0; k < 2; k++) a_m[i][k] = -(i + 1) * (k + 2);
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < C; j++) b_m[k][j] = (j + 3) * (k + 1) - 4;
    push_model(2);
    @(posedge clk); #1;
    start_job(2);
    send_beats(2, 1'b0);
    wait_idle();

    repeat (2) @(posedge clk);
    check("scoreboard_empty", 128'(sb.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
